// File: rtl/ac_motor_gate_control.sv
// ac_motor_gate_control
//   Converts the one-hot active-vector selects from the SVPWM vector controller
//   into dead-time protected high/low gate drives for a three-phase bridge.
//   A registered 3-bit target (bit 0 = phase 1) is decoded from sector + select.
//   Each phase then follows its target bit through an OFF/DEAD/HIGH/LOW state
//   machine, and a latched fault or a low enable forces every phase off.
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   en         in   gate enable
//   sector     in   [2:0] SVPWM sector, 0..5 legal
//   u_0..u_7   in   one-hot active-vector selects (V0, first, second, V7)
//   fault      in   power-stage fault
//   fault_clr  in   clears the latched fault when fault is low
//   gh, gl     out  [2:0] high/low-side gate drives, bit 0 = phase 1
//   fault_lat  out  sticky fault status
//   sel_err    out  flags an illegal select combination or sector

module ac_motor_gate_control #(
    parameter int DEAD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [2:0] sector,
    input  logic       u_0,
    input  logic       u_1,
    input  logic       u_2,
    input  logic       u_7,
    input  logic       fault,
    input  logic       fault_clr,
    output logic [2:0] gh,
    output logic [2:0] gl,
    output logic       fault_lat,
    output logic       sel_err
);

    typedef enum logic [1:0] {OFF, DEAD, HIGH, LOW} phase_state_e;

    localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES);
    localparam bit               NO_DEAD   = (DEAD_CYCLES == 0);

    logic [2:0]       target_q, target_d;
    logic             sel_err_q, sel_err_d;
    logic             fault_lat_q, fault_lat_d;
    logic             en_q;
    phase_state_e     state_q [3];
    phase_state_e     state_d [3];
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];
    logic [2:0]       gh_q, gh_d, gl_q, gl_d;

    logic [2:0]       selCount;
    logic             selValid;
    logic [2:0]       vecNum;
    logic             forceOff;

    // Phase states of each space vector, returned as {s3, s2, s1}.
    function automatic logic [2:0] vectorBits(input logic [2:0] n);
        case (n)
            3'd0:    vectorBits = 3'b000;
            3'd1:    vectorBits = 3'b001;
            3'd2:    vectorBits = 3'b011;
            3'd3:    vectorBits = 3'b010;
            3'd4:    vectorBits = 3'b110;
            3'd5:    vectorBits = 3'b100;
            3'd6:    vectorBits = 3'b101;
            default: vectorBits = 3'b111;
        endcase
    endfunction

    // Vector decode: u_1 picks the sector's leading active vector, u_2 the
    // trailing one (wrapping V6 -> V1). Anything but exactly one select, or an
    // out-of-range sector, keeps the old target and raises sel_err.
    always_comb begin
        selCount = {2'b00, u_0} + {2'b00, u_1} + {2'b00, u_2} + {2'b00, u_7};
        selValid = (selCount == 3'd1) && (sector <= 3'd5);
        vecNum   = 3'd7;
        if (u_0) begin
            vecNum = 3'd0;
        end else if (u_1) begin
            vecNum = sector + 3'd1;
        end else if (u_2) begin
            vecNum = (sector == 3'd5) ? 3'd1 : sector + 3'd2;
        end
        target_d    = selValid ? vectorBits(vecNum) : target_q;
        sel_err_d   = ~selValid;
        fault_lat_d = fault | (fault_lat_q & ~fault_clr);
    end

    // Per-phase next state. Leaving OFF waits for the registered enable so the
    // first dead time starts from the same pipeline stage as the target.
    // The counter value on entry to DEAD equals the number of both-off cycles;
    // exit happens on the edge where it would reach zero.
    always_comb begin
        forceOff = ~en | fault | fault_lat_q;
        for (int i = 0; i < 3; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (forceOff) begin
                state_d[i] = OFF;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    OFF: begin
                        if (en_q) begin
                            state_d[i] = DEAD;
                            cnt_d[i]   = DEAD_LOAD;
                        end
                    end
                    DEAD: begin
                        if (cnt_q[i] <= CNT_W'(1)) begin
                            state_d[i] = target_q[i] ? HIGH : LOW;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] - CNT_W'(1);
                        end
                    end
                    HIGH: begin
                        if (!target_q[i]) begin
                            state_d[i] = NO_DEAD ? LOW : DEAD;
                            cnt_d[i]   = DEAD_LOAD;
                        end
                    end
                    default: begin
                        if (target_q[i]) begin
                            state_d[i] = NO_DEAD ? HIGH : DEAD;
                            cnt_d[i]   = DEAD_LOAD;
                        end
                    end
                endcase
            end
            gh_d[i] = (state_d[i] == HIGH);
            gl_d[i] = (state_d[i] == LOW);
        end
    end

    // All state and the gate outputs are registered together, so the gates
    // drop asynchronously with reset and can never both be high for a phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q    <= '0;
            sel_err_q   <= 1'b0;
            fault_lat_q <= 1'b0;
            en_q        <= 1'b0;
            gh_q        <= '0;
            gl_q        <= '0;
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= OFF;
                cnt_q[i]   <= '0;
            end
        end else begin
            target_q    <= target_d;
            sel_err_q   <= sel_err_d;
            fault_lat_q <= fault_lat_d;
            en_q        <= en;
            gh_q        <= gh_d;
            gl_q        <= gl_d;
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign gh        = gh_q;
    assign gl        = gl_q;
    assign fault_lat = fault_lat_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_ac_motor_gate_control.sv
// tb_ac_motor_gate_control
//   Drives two builds of ac_motor_gate_control (DEAD_CYCLES=4 and 0) from the
//   same inputs and checks them against a behavioural model of the gate rules.

module tb_ac_motor_gate_control;

    localparam int DC_A = 4;

    logic       clk = 1'b0;
    logic       rst_n, en, fault, fault_clr, u_0, u_1, u_2, u_7;
    logic [2:0] sector;
    logic [2:0] ghA, glA, ghB, glB;
    logic       flA, flB, seA, seB;

    int nComp = 0;
    int nFail = 0;

    // Model state. Drive per phase: -1 nothing, 1 high side, 0 low side.
    logic [2:0] mTarget;
    logic       mFaultLat, mSelErr, mEnPrev;
    int         mIdle   [2][3];
    int         mRemain [2][3];
    int         mDrv    [2][3];
    logic [2:0] vecTab  [8];

    always #5 clk = ~clk;

    ac_motor_gate_control #(.DEAD_CYCLES(DC_A), .CNT_W(8)) dutA (
        .clk(clk), .rst_n(rst_n), .en(en), .sector(sector),
        .u_0(u_0), .u_1(u_1), .u_2(u_2), .u_7(u_7),
        .fault(fault), .fault_clr(fault_clr),
        .gh(ghA), .gl(glA), .fault_lat(flA), .sel_err(seA));

    ac_motor_gate_control #(.DEAD_CYCLES(0), .CNT_W(8)) dutB (
        .clk(clk), .rst_n(rst_n), .en(en), .sector(sector),
        .u_0(u_0), .u_1(u_1), .u_2(u_2), .u_7(u_7),
        .fault(fault), .fault_clr(fault_clr),
        .gh(ghB), .gl(glB), .fault_lat(flB), .sel_err(seB));

    task automatic modelReset();
        mTarget   = 3'b000;
        mFaultLat = 1'b0;
        mSelErr   = 1'b0;
        mEnPrev   = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3; i++) begin
                mIdle[k][i]   = 1;
                mRemain[k][i] = 0;
                mDrv[k][i]    = -1;
            end
        end
    endtask

    // One clock edge of the gate rules, using the inputs as sampled.
    task automatic modelStep();
        bit         forceOff;
        int         v, ones, dc, want;
        logic [2:0] pat;
        forceOff = !en || fault || mFaultLat;
        for (int k = 0; k < 2; k++) begin
            dc = (k == 0) ? DC_A : 0;
            for (int i = 0; i < 3; i++) begin
                want = int'(mTarget[i]);
                if (forceOff) begin
                    mIdle[k][i] = 1; mDrv[k][i] = -1; mRemain[k][i] = 0;
                end else if (mIdle[k][i] != 0) begin
                    if (mEnPrev) begin
                        mIdle[k][i]   = 0;
                        mDrv[k][i]    = -1;
                        mRemain[k][i] = (dc == 0) ? 1 : dc;
                    end
                end else if (mDrv[k][i] == -1) begin
                    mRemain[k][i]--;
                    if (mRemain[k][i] == 0) mDrv[k][i] = want;
                end else if (mDrv[k][i] != want) begin
                    if (dc == 0) begin
                        mDrv[k][i] = want;
                    end else begin
                        mDrv[k][i] = -1; mRemain[k][i] = dc;
                    end
                end
            end
        end
        ones = int'(u_0) + int'(u_1) + int'(u_2) + int'(u_7);
        if (ones == 1 && sector <= 3'd5) begin
            if (u_0)      v = 0;
            else if (u_1) v = int'(sector) + 1;
            else if (u_2) v = (int'(sector) + 1) % 6 + 1;
            else          v = 7;
            pat     = vecTab[v];
            mTarget = {pat[0], pat[1], pat[2]};
            mSelErr = 1'b0;
        end else begin
            mSelErr = 1'b1;
        end
        mFaultLat = fault ? 1'b1 : (fault_clr ? 1'b0 : mFaultLat);
        mEnPrev   = en;
    endtask

    task automatic checkVal(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        nComp++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        logic [2:0] eh [2];
        logic [2:0] el [2];
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3; i++) begin
                eh[k][i] = (mDrv[k][i] == 1);
                el[k][i] = (mDrv[k][i] == 0);
            end
        end
        checkVal("ghA", ghA, eh[0]);
        checkVal("glA", glA, el[0]);
        checkVal("ghB", ghB, eh[1]);
        checkVal("glB", glB, el[1]);
        checkVal("faultLatA", {2'b00, flA}, {2'b00, mFaultLat});
        checkVal("faultLatB", {2'b00, flB}, {2'b00, mFaultLat});
        checkVal("selErrA", {2'b00, seA}, {2'b00, mSelErr});
        checkVal("selErrB", {2'b00, seB}, {2'b00, mSelErr});
        checkVal("overlapA", ghA & glA, 3'b000);
        checkVal("overlapB", ghB & glB, 3'b000);
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
    endtask

    // sel is {u_7, u_2, u_1, u_0}.
    task automatic applyStimulus(input logic [2:0] sec, input logic [3:0] sel, input logic e,
                                 input logic f, input logic fc, input int cycles);
        sector = sec;
        {u_7, u_2, u_1, u_0} = sel;
        en = e; fault = f; fault_clr = fc;
        for (int c = 0; c < cycles; c++) tick();
    endtask

    initial begin
        int         riseAt;
        logic [2:0] sec;
        logic [3:0] sel;
        logic       e, f, fc;

        vecTab = '{3'b000, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101, 3'b111};
        modelReset();

        // Reset state, with the first command already waiting.
        rst_n = 1'b0;
        sector = 3'd0; {u_7, u_2, u_1, u_0} = 4'b0010;
        en = 1'b1; fault = 1'b0; fault_clr = 1'b0;
        #12;
        checkOutput();

        // Release: target on edge 1, OFF->DEAD on edge 2, drive on edge 6.
        @(negedge clk);
        rst_n = 1'b1;
        riseAt = 0;
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (ghA[0] === 1'b1) begin
                riseAt = n;
                break;
            end
        end
        checkVal("firstRiseEdge", 3'(riseAt), 3'd6);
        checkVal("firstRiseLow", {1'b0, glA[2:1]}, 3'b011);

        // Sector 2, leading then trailing vector.
        applyStimulus(3'd2, 4'b0010, 1'b1, 1'b0, 1'b0, 8);
        applyStimulus(3'd2, 4'b0100, 1'b1, 1'b0, 1'b0, 8);

        // Two selects at once: one-cycle sel_err, target held.
        applyStimulus(3'd2, 4'b0110, 1'b1, 1'b0, 1'b0, 1);
        checkVal("selErrPulse", {2'b00, seA}, 3'b001);
        applyStimulus(3'd2, 4'b0100, 1'b1, 1'b0, 1'b0, 3);
        // Illegal sector.
        applyStimulus(3'd6, 4'b0100, 1'b1, 1'b0, 1'b0, 1);
        applyStimulus(3'd2, 4'b0100, 1'b1, 1'b0, 1'b0, 2);

        // One-cycle fault while driving, then clear and restart.
        applyStimulus(3'd2, 4'b0100, 1'b1, 1'b1, 1'b0, 1);
        checkVal("faultGatesOff", ghA | glA, 3'b000);
        applyStimulus(3'd2, 4'b0100, 1'b1, 1'b0, 1'b0, 3);
        applyStimulus(3'd2, 4'b0100, 1'b1, 1'b1, 1'b1, 1);
        applyStimulus(3'd2, 4'b0100, 1'b1, 1'b0, 1'b1, 1);
        applyStimulus(3'd2, 4'b0100, 1'b1, 1'b0, 1'b0, 8);

        // Target toggles back while phases 2/3 are in dead time.
        applyStimulus(3'd0, 4'b0010, 1'b1, 1'b0, 1'b0, 8);
        applyStimulus(3'd0, 4'b1000, 1'b1, 1'b0, 1'b0, 1);
        applyStimulus(3'd0, 4'b0010, 1'b1, 1'b0, 1'b0, 8);

        // Enable drop forces everything off.
        applyStimulus(3'd0, 4'b0010, 1'b0, 1'b0, 1'b0, 2);
        applyStimulus(3'd0, 4'b0010, 1'b1, 1'b0, 1'b0, 8);

        // Asynchronous reset in the middle of a dead time.
        applyStimulus(3'd0, 4'b1000, 1'b1, 1'b0, 1'b0, 2);
        #2;
        rst_n = 1'b0;
        #1;
        checkVal("asyncRstGhA", ghA, 3'b000);
        checkVal("asyncRstGlA", glA, 3'b000);
        checkVal("asyncRstGhB", ghB, 3'b000);
        checkVal("asyncRstGlB", glB, 3'b000);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(3'd0, 4'b1000, 1'b1, 1'b0, 1'b0, 8);

        // Randomised segments.
        for (int s = 0; s < 60; s++) begin
            sec = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 5)) : 3'($urandom_range(6, 7));
            if ($urandom_range(0, 9) < 8) sel = 4'(1 << $urandom_range(0, 3));
            else                           sel = 4'($urandom_range(0, 15));
            e  = ($urandom_range(0, 19) != 0);
            f  = ($urandom_range(0, 14) == 0);
            fc = ($urandom_range(0, 3) == 0);
            applyStimulus(sec, sel, e, f, fc, 1);
            applyStimulus(sec, sel, e, 1'b0, 1'b0, $urandom_range(1, 10));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nFail);
        $finish;
    end

endmodule
